// File: rtl/mc_avl_pkg.sv
// Shared definitions for the simulation Avalon-MM memory model.
//   - Avalon port widths (address, data, byte enable, burst size)
//   - Controller FSM state encoding
//   - Backpressure LFSR tap mask
//   - burst_len(): maps the size field to a beat count (0 means 1 beat)
package mc_avl_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 128;
  localparam int BE_W   = 16;
  localparam int SIZE_W = 5;
  localparam int LAT_W  = 4;

  // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0].
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DATA  = 2'd3
  } mc_state_e;

  function automatic logic [SIZE_W-1:0] burst_len(input logic [SIZE_W-1:0] size);
    return (size == '0) ? SIZE_W'(1) : size;
  endfunction

endpackage

// File: rtl/mc_avl_sim_ram.sv
// 1R1W synchronous storage array for the memory model.
//   clk   : clock
//   rst_n : synchronous active-low reset (clears the read register only)
//   we    : write enable, waddr/be/wdata give the beat; only bytes with be=1 change
//   re    : read enable, raddr is sampled on the clock edge and rdata updates then
//   rdata : registered read data
// Contents survive reset.
module mc_avl_sim_ram
  import mc_avl_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [BE_W-1:0]       be,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Sampling the address on the edge gives this path one cycle of read latency.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mc_avl_sim_mem.sv
// Avalon-MM memory model on the controller side of the LTC port.
// Accepts read/write bursts, returns read data after RD_LAT cycles, and can
// throttle ready with an LFSR when STALL_EN=1.
//   clkrst_mem_clk / clkrst_mem_rst_n : clock, synchronous active-low reset
//   ltc2mc_avl_*_0 (in)  : addr, be, burstbegin, read_req, write_req, size, wdata
//   ltc2mc_avl_ready_0       : request/beat accepted when high (combinational)
//   ltc2mc_avl_rdata_0       : registered read data
//   ltc2mc_avl_rdata_valid_0 : registered read data valid
//   mc_err                   : sticky protocol-error flag, cleared only by reset
module mc_avl_sim_mem
  import mc_avl_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 12,
  parameter int         RD_LAT     = 4,
  parameter bit         STALL_EN   = 1'b0,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter string      INIT_FILE  = ""
) (
  input  logic              clkrst_mem_clk,
  input  logic              clkrst_mem_rst_n,
  input  logic [ADDR_W-1:0] ltc2mc_avl_addr_0,
  input  logic [BE_W-1:0]   ltc2mc_avl_be_0,
  input  logic              ltc2mc_avl_burstbegin_0,
  input  logic              ltc2mc_avl_read_req_0,
  input  logic              ltc2mc_avl_write_req_0,
  input  logic [SIZE_W-1:0] ltc2mc_avl_size_0,
  input  logic [DATA_W-1:0] ltc2mc_avl_wdata_0,
  output logic              ltc2mc_avl_ready_0,
  output logic [DATA_W-1:0] ltc2mc_avl_rdata_0,
  output logic              ltc2mc_avl_rdata_valid_0,
  output logic              mc_err
);

  localparam int AW = DEPTH_LOG2;

  mc_state_e         state, state_nxt;
  logic [7:0]        lfsr;
  logic [AW-1:0]     cur_addr;
  logic [SIZE_W-1:0] beat_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              rdata_valid_q;
  logic              err_q;

  logic              stall, rdy;
  logic              wr_acc, rd_acc, fetch, err_set;
  logic [AW-1:0]     acc_addr;
  logic [SIZE_W-1:0] in_len;
  logic              addr_unused;

  // Only the low DEPTH_LOG2 address bits select storage.
  assign addr_unused = ^ltc2mc_avl_addr_0;

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    fetch     = 1'b0;
    err_set   = 1'b0;
    in_len    = burst_len(ltc2mc_avl_size_0);
    stall     = STALL_EN && (lfsr[1:0] == 2'b00);
    acc_addr  = (state == IDLE) ? ltc2mc_avl_addr_0[AW-1:0] : cur_addr;

    case (state)
      IDLE: begin
        rdy     = !stall;
        err_set = ltc2mc_avl_read_req_0 && ltc2mc_avl_write_req_0;
        if (rdy && ltc2mc_avl_write_req_0) begin
          wr_acc = 1'b1;
          if (in_len != SIZE_W'(1)) state_nxt = WR_BURST;
        end else if (rdy && ltc2mc_avl_read_req_0) begin
          rd_acc = 1'b1;
          if (RD_LAT == 1) begin
            state_nxt = RD_DATA;
            fetch     = 1'b1;
          end else begin
            state_nxt = RD_WAIT;
          end
        end
      end
      WR_BURST: begin
        rdy     = !stall;
        err_set = ltc2mc_avl_read_req_0 || ltc2mc_avl_burstbegin_0;
        if (rdy && ltc2mc_avl_write_req_0) begin
          wr_acc = 1'b1;
          if (beat_cnt == SIZE_W'(1)) state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        // The fetch issued here lands in the output register next cycle.
        if (lat_cnt == LAT_W'(1)) begin
          state_nxt = RD_DATA;
          fetch     = 1'b1;
        end
      end
      RD_DATA: begin
        // beat_cnt counts beats not yet fetched from the array.
        if (beat_cnt != '0) fetch = 1'b1;
        else                state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clkrst_mem_clk) begin
    if (!clkrst_mem_rst_n) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state         <= state_nxt;
      lfsr          <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      rdata_valid_q <= fetch;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Burst address / count tracking
  always_ff @(posedge clkrst_mem_clk) begin
    if (wr_acc) begin
      cur_addr <= acc_addr + 1'b1;
      beat_cnt <= ((state == IDLE) ? in_len : beat_cnt) - 1'b1;
    end else if (fetch) begin
      cur_addr <= acc_addr + 1'b1;
      beat_cnt <= (rd_acc ? in_len : beat_cnt) - 1'b1;
    end else if (rd_acc) begin
      cur_addr <= acc_addr;
      beat_cnt <= in_len;
    end
    if (rd_acc)                lat_cnt <= LAT_W'(RD_LAT - 1);
    else if (state == RD_WAIT) lat_cnt <= lat_cnt - 1'b1;
  end

  mc_avl_sim_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clkrst_mem_clk),
    .rst_n (clkrst_mem_rst_n),
    .we    (wr_acc),
    .waddr (acc_addr),
    .be    (ltc2mc_avl_be_0),
    .wdata (ltc2mc_avl_wdata_0),
    .re    (fetch),
    .raddr (acc_addr),
    .rdata (ltc2mc_avl_rdata_0)
  );

  assign ltc2mc_avl_ready_0       = rdy;
  assign ltc2mc_avl_rdata_valid_0 = rdata_valid_q;
  assign mc_err                   = err_q;

endmodule

// File: tb/tb_mc_avl_sim_mem.sv
// Directed bench for mc_avl_sim_mem. Two instances share the request bus:
// dut_a (DEPTH_LOG2=12, no stall) and dut_b (DEPTH_LOG2=4, STALL_EN=1).
// sel picks which instance receives requests and whose outputs are observed.
module tb_mc_avl_sim_mem;

  localparam int RD_LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel;
  logic [24:0]  addr;
  logic [15:0]  be;
  logic         bb, rreq, wreq;
  logic [4:0]   size;
  logic [127:0] wdata;

  logic         rdy_a, rdy_b, rv_a, rv_b, err_a, err_b;
  logic [127:0] rd_a, rd_b;
  logic         rdy, rv, err;
  logic [127:0] rdat;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_seen = 0;

  always #5 clk = ~clk;

  assign rdy  = sel ? rdy_b : rdy_a;
  assign rv   = sel ? rv_b  : rv_a;
  assign err  = sel ? err_b : err_a;
  assign rdat = sel ? rd_b  : rd_a;

  mc_avl_sim_mem #(.DEPTH_LOG2(12), .RD_LAT(RD_LAT), .STALL_EN(1'b0)) dut_a (
    .clkrst_mem_clk           (clk),
    .clkrst_mem_rst_n         (rst_n),
    .ltc2mc_avl_addr_0        (addr),
    .ltc2mc_avl_be_0          (be),
    .ltc2mc_avl_burstbegin_0  (bb & !sel),
    .ltc2mc_avl_read_req_0    (rreq & !sel),
    .ltc2mc_avl_write_req_0   (wreq & !sel),
    .ltc2mc_avl_size_0        (size),
    .ltc2mc_avl_wdata_0       (wdata),
    .ltc2mc_avl_ready_0       (rdy_a),
    .ltc2mc_avl_rdata_0       (rd_a),
    .ltc2mc_avl_rdata_valid_0 (rv_a),
    .mc_err                   (err_a)
  );

  mc_avl_sim_mem #(.DEPTH_LOG2(4), .RD_LAT(RD_LAT), .STALL_EN(1'b1), .LFSR_SEED(8'hA5)) dut_b (
    .clkrst_mem_clk           (clk),
    .clkrst_mem_rst_n         (rst_n),
    .ltc2mc_avl_addr_0        (addr),
    .ltc2mc_avl_be_0          (be),
    .ltc2mc_avl_burstbegin_0  (bb & sel),
    .ltc2mc_avl_read_req_0    (rreq & sel),
    .ltc2mc_avl_write_req_0   (wreq & sel),
    .ltc2mc_avl_size_0        (size),
    .ltc2mc_avl_wdata_0       (wdata),
    .ltc2mc_avl_ready_0       (rdy_b),
    .ltc2mc_avl_rdata_0       (rd_b),
    .ltc2mc_avl_rdata_valid_0 (rv_b),
    .mc_err                   (err_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    wreq = 1'b0; rreq = 1'b0; bb = 1'b0;
    addr = '0; size = '0; wdata = '0; be = '0;
  endtask

  // Called at a negedge with a request driven; returns once ready is high,
  // so the following posedge accepts it.
  task automatic wait_ready();
    int tries = 0;
    #1;
    while (!rdy && tries < 100) begin
      stall_seen++;
      tries++;
      @(negedge clk);
      #1;
    end
    if (!rdy) check("ready_timeout", rdy, 1);
  endtask

  task automatic write_burst(input logic [24:0] a, input int n,
                             input logic [127:0] base, input logic [15:0] b);
    for (int k = 0; k < n; k++) begin
      wreq = 1'b1; bb = (k == 0); addr = a; size = 5'(n);
      wdata = base + 128'(k); be = b;
      wait_ready();
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // Beat k expected = base + k, visible exactly RD_LAT+k cycles after accept.
  task automatic read_burst(input logic [24:0] a, input int n,
                            input logic [127:0] base, input string tag);
    rreq = 1'b1; bb = 1'b1; addr = a; size = 5'(n);
    wait_ready();
    @(negedge clk);
    idle_inputs();
    for (int c = 1; c <= RD_LAT + n + 1; c++) begin
      if (c >= RD_LAT && c < RD_LAT + n) begin
        check({tag, "_vld"}, rv, 1);
        check({tag, "_dat"}, rdat, base + 128'(c - RD_LAT));
      end else begin
        check({tag, "_vld"}, rv, 0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    sel   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vld",   rv,   0);
    check("rst_rdata", rdat, 0);
    check("rst_err",   err,  0);
    check("rst_ready", rdy,  1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write then read with RD_LAT latency.
    write_burst(25'h10, 1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF);
    read_burst(25'h10, 1, 128'h00112233_44556677_8899AABB_CCDDEEFF, "single");
    check("single_err", err, 0);

    // Byte-enable merge: bytes 7:4 cleared only.
    write_burst(25'h5, 1, {128{1'b1}}, 16'hFFFF);
    write_burst(25'h5, 1, 128'h0, 16'h00F0);
    read_burst(25'h5, 1, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF, "bemerge");

    // Simultaneous read and write in IDLE: write wins, error sticks.
    wreq = 1'b1; rreq = 1'b1; bb = 1'b1; addr = 25'h20; size = 5'd1;
    wdata = 128'hDEAD_BEEF; be = 16'hFFFF;
    wait_ready();
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      check("proto_no_read", rv, 0);
      @(negedge clk);
    end
    check("proto_err", err, 1);
    read_burst(25'h20, 1, 128'hDEAD_BEEF, "proto_wr");
    check("proto_err_held", err, 1);

    // Reset during RD_DATA of an 8-beat read, after 3 beats.
    write_burst(25'h40, 8, 128'hA0, 16'hFFFF);
    rreq = 1'b1; bb = 1'b1; addr = 25'h40; size = 5'd8;
    wait_ready();
    @(negedge clk);
    idle_inputs();
    for (int c = 1; c <= RD_LAT + 2; c++) begin
      if (c >= RD_LAT) begin
        check("midrst_vld", rv, 1);
        check("midrst_dat", rdat, 128'hA0 + 128'(c - RD_LAT));
      end else begin
        check("midrst_vld", rv, 0);
      end
      if (c < RD_LAT + 2) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_vld_after", rv, 0);
    check("midrst_rdata_after", rdat, 0);
    check("midrst_err_clr", err, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("midrst_no_beats", rv, 0);
    end
    read_burst(25'h40, 8, 128'hA0, "midrst_readback");

    // Burst wrap and backpressure on the 16-word, stalling instance.
    sel = 1'b1;
    @(negedge clk);
    write_burst(25'd14, 4, 128'd1, 16'hFFFF);
    read_burst(25'd14, 4, 128'd1, "wrap");
    read_burst(25'd0, 1, 128'd3, "wrap_addr0");

    stall_seen = 0;
    write_burst(25'd0, 16, 128'h100, 16'hFFFF);
    check("stall_seen", 128'(stall_seen != 0), 1);
    read_burst(25'd0, 16, 128'h100, "bp_readback");
    check("bp_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
